// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and the golden table
// of the 3-input Circuit it is normally wrapped around.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bit i is the Circuit output for input index i = {A,B,C}.
  localparam logic [7:0] CIRCUIT_TT = 8'h1A;

endpackage

// File: rtl/sweep_settle_cnt.sv
// Loadable down-counter that times how long each vector is held before sampling.
// It stops at zero and flags it so the FSM knows the vector has settled.
module sweep_settle_cnt
  import sweep_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Clocked exhaustive sweep of a small combinational circuit: drives every input vector,
// captures the output into a truth table and compares it against the golden table.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int                  N_IN     = 3,
  parameter int                  SETTLE   = 1,
  parameter logic [2**N_IN-1:0]  EXPECTED = CIRCUIT_TT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 pass,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      first_fail
);

  localparam int                NV          = 2**N_IN;
  localparam int                CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]     SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0]   LAST_IDX    = N_IN'(NV - 1);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NV-1:0]     table_q, table_d;
  logic              pass_q, pass_d;
  logic              fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]   first_fail_q, first_fail_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  sweep_settle_cnt #(
    .W (CW)
  ) u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    table_d      = table_q;
    pass_d       = pass_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = DRIVE;
          idx_d        = '0;
          busy_d       = 1'b1;
          table_d      = '0;
          pass_d       = 1'b0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
          cnt_load     = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_zero) begin
          state_d = SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SAMPLE: begin
        table_d[idx_q] = dut_out;
        // Only the lowest mismatching index is kept.
        if ((dut_out != EXPECTED[idx_q]) && !fail_valid_q) begin
          fail_valid_d = 1'b1;
          first_fail_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          pass_d  = (table_d == EXPECTED);
        end else begin
          state_d  = DRIVE;
          idx_d    = idx_q + 1'b1;
          cnt_load = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      table_q      <= '0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      table_q      <= table_d;
      pass_q       <= pass_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign dut_in     = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = table_q;
  assign pass       = pass_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two sweepers (SETTLE=1 and SETTLE=3) around a modelled
// Circuit whose output can be forced good, stuck-at-0 or inverted.
module tb_truth_table_sweeper;

  typedef struct {
    logic [1:0] mode;
    logic       sel;
    logic [7:0] tt;
    logic       pass;
    logic       fv;
    logic [2:0] ff;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       start0, start1;
  logic [1:0] mode;
  logic       sel;

  logic [2:0] dut_in0, dut_in1, first_fail0, first_fail1;
  logic       dut_out0, dut_out1;
  logic       busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
  logic [7:0] table0, table1;

  logic [2:0] m_dut_in, m_first_fail;
  logic       m_busy, m_done, m_pass, m_fv;
  logic [7:0] m_table;

  int   n_checks;
  int   n_pass;
  vec_t exp_q[$];
  vec_t vecs[5];

  // Reference Circuit: O is high for {A,B,C} = 001, 011, 100.
  function automatic logic circuit(input logic [2:0] v);
    return (!v[2] & v[0]) | (v[2] & !v[1] & !v[0]);
  endfunction

  assign dut_out0 = (mode == 2'd0) ? circuit(dut_in0) :
                    (mode == 2'd1) ? 1'b0 : !circuit(dut_in0);
  assign dut_out1 = circuit(dut_in1);

  assign m_dut_in     = sel ? dut_in1     : dut_in0;
  assign m_busy       = sel ? busy1       : busy0;
  assign m_done       = sel ? done1       : done0;
  assign m_table      = sel ? table1      : table0;
  assign m_pass       = sel ? pass1       : pass0;
  assign m_fv         = sel ? fv1         : fv0;
  assign m_first_fail = sel ? first_fail1 : first_fail0;

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start0), .dut_in(dut_in0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .table_out(table0), .pass(pass0),
    .fail_valid(fv0), .first_fail(first_fail0)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .table_out(table1), .pass(pass1),
    .fail_valid(fv1), .first_fail(first_fail1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_dut_in"}, m_dut_in, 0);
    checkOutput({tag, "_busy"}, m_busy, 0);
    checkOutput({tag, "_done"}, m_done, 0);
    checkOutput({tag, "_table"}, m_table, 0);
    checkOutput({tag, "_pass"}, m_pass, 0);
    checkOutput({tag, "_fail_valid"}, m_fv, 0);
    checkOutput({tag, "_first_fail"}, m_first_fail, 0);
  endtask

  // Called in the cycle right after the edge that accepted start.
  task automatic runSweepChecks(input int settle);
    int j;
    bit seen;
    vec_t e;
    j = 0;
    seen = 0;
    while (j <= 8 * (settle + 1) + 5 && !seen) begin
      if (m_done) begin
        seen = 1;
      end else begin
        if (j < 8 * (settle + 1)) begin
          checkOutput("dut_in_step", m_dut_in, j / (settle + 1));
          checkOutput("busy_in_sweep", m_busy, 1);
        end
        @(negedge clk);
        j++;
      end
    end
    checkOutput("done_seen", seen, 1);
    checkOutput("done_latency", j, 8 * (settle + 1) + 1);
    checkOutput("busy_at_done", m_busy, 0);
    checkOutput("scoreboard_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("table_out", m_table, e.tt);
      checkOutput("pass", m_pass, e.pass);
      checkOutput("fail_valid", m_fv, e.fv);
      checkOutput("first_fail", m_first_fail, e.ff);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    mode = v.mode;
    sel  = v.sel;
    if (v.sel) start1 = 1'b1;
    else       start0 = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    runSweepChecks(v.sel ? 3 : 1);
  endtask

  initial begin
    int  k;
    bit  saw_done;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    start0   = 1'b0;
    start1   = 1'b0;
    mode     = 2'd0;
    sel      = 1'b0;

    vecs[0] = '{mode: 2'd0, sel: 1'b0, tt: 8'h1A, pass: 1'b1, fv: 1'b0, ff: 3'd0};
    vecs[1] = '{mode: 2'd1, sel: 1'b0, tt: 8'h00, pass: 1'b0, fv: 1'b1, ff: 3'd1};
    vecs[2] = '{mode: 2'd2, sel: 1'b0, tt: 8'hE5, pass: 1'b0, fv: 1'b1, ff: 3'd0};
    vecs[3] = '{mode: 2'd0, sel: 1'b1, tt: 8'h1A, pass: 1'b1, fv: 1'b0, ff: 3'd0};
    vecs[4] = '{mode: 2'd0, sel: 1'b0, tt: 8'h1A, pass: 1'b1, fv: 1'b0, ff: 3'd0};

    repeat (2) @(negedge clk);
    sel = 1'b0;
    checkAllZero("reset0");
    sel = 1'b1;
    checkAllZero("reset1");
    rst = 1'b0;
    sel = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset in the middle of vector 4 of a golden sweep.
    @(negedge clk);
    mode = 2'd0;
    sel  = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (m_dut_in != 3'd4 && k < 30) begin
      @(negedge clk);
      k++;
    end
    checkOutput("reached_vector4", m_dut_in, 4);
    checkOutput("partial_table_bits", m_table, 8'h0A);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("midreset");
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_done || m_busy) saw_done = 1;
    end
    checkOutput("no_activity_after_reset", saw_done, 0);
    applyStimulus(vecs[0]);

    // Start held high: sweeps restart back-to-back, results cleared at each restart.
    @(negedge clk);
    mode = 2'd0;
    sel  = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(vecs[0]);
      runSweepChecks(1);
      if (r == 2) start0 = 1'b0;
      @(negedge clk);
      if (r < 2) begin
        checkOutput("restart_table_cleared", m_table, 0);
        checkOutput("restart_pass_cleared", m_pass, 0);
        checkOutput("restart_busy", m_busy, 1);
        checkOutput("restart_dut_in", m_dut_in, 0);
      end else begin
        checkOutput("idle_busy", m_busy, 0);
        checkOutput("idle_done_single_pulse", m_done, 0);
        checkOutput("idle_dut_in_held", m_dut_in, 7);
        checkOutput("idle_pass_held", m_pass, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
